alarm_sequencer: RTL
====================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 SHALL have parameter SNOOZE_MIN, default 5, minutes per snooze interval (1..15).
REQ-002 SHALL have parameter RING_TIMEOUT_MIN, default 10, minutes of unanswered ringing before auto-stop (1..15).
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (0..3).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports tick_min  input  1  one-cycle pulse on the cycle cur_hour/cur_min take a new value; tick_sec  input  1  one-cycle pulse per second.
REQ-007 SHALL have ports cur_hour  input  5  (0..23); cur_min  input  6  (0..59); alarm_hour  input  5; alarm_min  input  6.
REQ-008 SHALL have ports alarm_en  input  1  arm level; snooze_btn, dismiss_btn  input  1 each, synchronized levels.
REQ-009 SHALL have outputs ringing, snoozing, buzzer, missed  1 each; snooze_left  output  2  remaining snoozes.

Function
REQ-010 SHALL implement FSM states IDLE, ARMED, RINGING, SNOOZE.
REQ-011 IDLE->ARMED on the cycle after alarm_en sampled high; alarm_en low in any state -> IDLE next cycle, overriding all other events.
REQ-012 ARMED->RINGING only in a cycle with tick_min=1 and {cur_hour,cur_min}=={alarm_hour,alarm_min}; no match evaluation without tick_min.
REQ-013 Entering RINGING from ARMED SHALL load snooze_left=MAX_SNOOZE and clear ring-minute counter.
REQ-014 Buttons SHALL act on rising edge only (previous-level register); held buttons act once.
REQ-015 RINGING + dismiss edge -> ARMED; clears missed.
REQ-016 RINGING + snooze edge + snooze_left>0 -> SNOOZE, snooze_left decremented; snooze_left==0 -> edge ignored, stays RINGING.
REQ-017 Dismiss and snooze edges in same cycle -> dismiss wins.
REQ-018 RINGING counts tick_min; on RING_TIMEOUT_MIN-th tick -> ARMED with missed=1 (sticky until dismiss edge in RINGING, alarm_en low, or rst).
REQ-019 SNOOZE counts tick_min; on SNOOZE_MIN-th tick -> RINGING with ring-minute counter cleared, snooze_left retained; dismiss edge in SNOOZE -> ARMED.
REQ-020 Dismissal in the matching minute SHALL NOT retrigger (next evaluation is next tick_min with new time).
REQ-021 ringing=1 iff state RINGING; snoozing=1 iff state SNOOZE; outputs registered, valid the cycle after the transition edge.
REQ-022 Minute counters SHALL be 4 bits, saturating never required (reset on every state entry).

Reset
REQ-023 rst=1 SHALL force IDLE, ringing=0, snoozing=0, buzzer=0, missed=0, snooze_left=0, counters=0, button history=0, beep phase=0, regardless of state or concurrent ticks.
REQ-024 Reset mid-ring SHALL silence buzzer on the next cycle; after release, ARMED requires alarm_en high.

Configuration
REQ-025 Macro ALARM_BUZZER_PULSE_EN defined: beep phase toggles on each tick_sec while RINGING, cleared otherwise; buzzer=ringing AND phase (1 s on/1 s off, first second silent).
REQ-026 Macro undefined: buzzer=ringing (continuous); tick_sec unused but port retained.

Structure
REQ-027 Package alarm_pkg SHALL hold the state enum (2-bit) and the hour/minute width constants (5, 6).
REQ-028 One sub-module rise_detect (1-bit registered rising-edge detector, synchronous active-high reset) SHALL be instantiated per button.

Verification
REQ-029 Alarm 07:05, alarm_en=1, drive cur=07:05 with tick_min -> ringing=1 next cycle, snooze_left=3.
REQ-030 Ringing, snooze pulse -> snoozing=1, snooze_left=2; 5 tick_min -> ringing=1; repeat until snooze_left=0, further snooze ignored.
REQ-031 Ringing, 10 tick_min without buttons -> ringing=0, missed=1, state ARMED; next matching tick -> ringing again.
REQ-032 Snooze and dismiss high same cycle while ringing -> ARMED, snooze_left unchanged, missed=0; dismiss held 20 cycles acts once.
REQ-033 Ringing, rst for 1 cycle -> all outputs 0 next cycle; alarm_en low mid-SNOOZE -> IDLE next cycle.
REQ-034 With ALARM_BUZZER_PULSE_EN, ringing and 4 tick_sec -> buzzer pattern 0,1,0,1; without macro buzzer constant 1.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared FSM state encoding and time field widths for the alarm sequencer
package alarm_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W = 6;
  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;
endpackage

// File: rtl/alarm_sequencer_rise_detect.sv
// rise_detect: one-cycle pulse on a 0->1 transition of d (ports: clk, rst, d in; rise out)
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk) prev <= rst ? 1'b0 : d;
  assign rise = d & ~prev;
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: arm/ring/snooze/timeout alarm FSM with registered status outputs
//   in : clk, rst, tick_min, tick_sec, cur_hour/cur_min, alarm_hour/alarm_min, alarm_en, snooze_btn, dismiss_btn
//   out: ringing, snoozing, buzzer, missed, snooze_left
//   ALARM_BUZZER_PULSE_EN: buzzer beeps 1 s on / 1 s off (first second silent) instead of sounding continuously
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int MAX_SNOOZE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_min,
  input  logic              tick_sec,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic              alarm_en,
  input  logic              snooze_btn,
  input  logic              dismiss_btn,
  output logic              ringing,
  output logic              snoozing,
  output logic              buzzer,
  output logic              missed,
  output logic [1:0]        snooze_left
);
  state_t     state;
  logic [3:0] cnt;
  logic       snz_edge, dis_edge, match;
  rise_detect u_snz (.clk(clk), .rst(rst), .d(snooze_btn), .rise(snz_edge));
  rise_detect u_dis (.clk(clk), .rst(rst), .d(dismiss_btn), .rise(dis_edge));
  assign match = {cur_hour, cur_min} == {alarm_hour, alarm_min};
`ifdef ALARM_BUZZER_PULSE_EN
  logic phase;
  assign buzzer = ringing & phase;
`else
  logic unused_tick_sec;
  assign unused_tick_sec = tick_sec;
  assign buzzer = ringing;
`endif
  always_ff @(posedge clk) begin
`ifdef ALARM_BUZZER_PULSE_EN
    phase <= 1'b0;
`endif
    if (rst || !alarm_en) begin
      state <= IDLE;
      ringing <= 1'b0;
      snoozing <= 1'b0;
      missed <= 1'b0;
      snooze_left <= 2'd0;
      cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: state <= ARMED;
        ARMED: if (tick_min && match) begin
          state <= RINGING;
          ringing <= 1'b1;
          snooze_left <= 2'(MAX_SNOOZE);
          cnt <= 4'd0;
        end
        RINGING: if (dis_edge) begin
          state <= ARMED;
          ringing <= 1'b0;
          missed <= 1'b0;
        end else if (snz_edge && snooze_left != 2'd0) begin
          state <= SNOOZE;
          ringing <= 1'b0;
          snoozing <= 1'b1;
          snooze_left <= snooze_left - 2'd1;
          cnt <= 4'd0;
        end else if (tick_min && cnt == 4'(RING_TIMEOUT_MIN - 1)) begin
          state <= ARMED;
          ringing <= 1'b0;
          missed <= 1'b1;
        end else begin
          cnt <= cnt + 4'(tick_min);
`ifdef ALARM_BUZZER_PULSE_EN
          phase <= phase ^ tick_sec;
`endif
        end
        SNOOZE: if (dis_edge) begin
          state <= ARMED;
          snoozing <= 1'b0;
        end else if (tick_min && cnt == 4'(SNOOZE_MIN - 1)) begin
          state <= RINGING;
          snoozing <= 1'b0;
          ringing <= 1'b1;
          cnt <= 4'd0;
        end else cnt <= cnt + 4'(tick_min);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
